cpu_step_ctrl: RTL and testbench

Board-level execution controller that sits directly upstream of the single-cycle RV32I core and generates its `clk`. It turns a raw push-button into debounced single steps and a run switch into a divided free-running clock. In run mode it halts on a PC breakpoint so `output_mux` on the hex displays can be inspected instruction by instruction. It also counts the CPU cycles issued.

---
 rtl/cpu_step_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - debounced single-step / divided free-run clock generator with PC breakpoint
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_clk,
    output logic        halted,
    output logic        bp_hit,
    output logic [31:0] step_count
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = $clog2(RUN_DIV);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    logic             btn_meta;
    logic             btn_sync;
    logic             run_meta;
    logic             run_sync;
    logic             bpen_meta;
    logic             bpen_sync;

    logic             deb_level;
    logic             deb_prev;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;

    // Two-flop synchronisers for the asynchronous button and the board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            run_meta  <= 1'b0;
            run_sync  <= 1'b0;
            bpen_meta <= 1'b0;
            bpen_sync <= 1'b0;
        end else begin
            btn_meta  <= btn_step;
            btn_sync  <= btn_meta;
            run_meta  <= sw_run;
            run_sync  <= run_meta;
            bpen_meta <= bp_en;
            bpen_sync <= bpen_meta;
        end
    end

    // Accept a new button level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (btn_sync != deb_level) begin
            if (deb_cnt == DEB_LAST) begin
                deb_level <= btn_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // One-cycle press pulse on a debounced rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev <= 1'b0;
            press    <= 1'b0;
        end else begin
            deb_prev <= deb_level;
            press    <= deb_level & ~deb_prev;
        end
    end

    // Execution FSM: owns the divider, the CPU clock pulse, the status flags and the cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_HALT;
            div_cnt    <= '0;
            cpu_clk    <= 1'b0;
            halted     <= 1'b1;
            bp_hit     <= 1'b0;
            step_count <= '0;
        end else begin
            cpu_clk <= 1'b0;
            case (state)
                S_HALT: begin
                    if (press) begin
                        state  <= S_STEP;
                        halted <= 1'b0;
                    end else if (run_sync) begin
                        state   <= S_RUN;
                        div_cnt <= '0;
                        halted  <= 1'b0;
                    end
                end
                S_STEP: begin
                    cpu_clk    <= 1'b1;
                    step_count <= step_count + 32'd1;
                    state      <= S_HALT;
                    halted     <= 1'b1;
                end
                S_RUN: begin
                    if (!run_sync) begin
                        // Dropping the switch mid-count abandons the period without a pulse.
                        state   <= S_HALT;
                        div_cnt <= '0;
                        halted  <= 1'b1;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bpen_sync && (pc == bp_addr)) begin
                            // Stop before executing the breakpoint instruction.
                            state  <= S_BREAK;
                            halted <= 1'b1;
                            bp_hit <= 1'b1;
                        end else begin
                            cpu_clk    <= 1'b1;
                            step_count <= step_count + 32'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                S_BREAK: begin
                    if (press) begin
                        // Stepping out of BREAK executes the breakpoint instruction itself.
                        state  <= S_STEP;
                        halted <= 1'b0;
                        bp_hit <= 1'b0;
                    end else if (!run_sync) begin
                        state  <= S_HALT;
                        bp_hit <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                    bp_hit <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 3;

    localparam int M_HALT  = 0;
    localparam int M_STEP  = 1;
    localparam int M_RUN   = 2;
    localparam int M_BREAK = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_step = 1'b0;
    logic        sw_run = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        cpu_clk;
    logic        halted;
    logic        bp_hit;
    logic [31:0] step_count;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int pulses = 0;
    int pulse_cyc[$];

    // Behavioural model state
    int          mode = M_HALT;
    int          run_cycles = 0;
    logic        m_cpu = 1'b0;
    logic        m_halted = 1'b1;
    logic        m_bp = 1'b0;
    logic [31:0] m_count = 32'h0;
    logic        btn_h[2] = '{1'b0, 1'b0};
    logic        run_h[2] = '{1'b0, 1'b0};
    logic        bpen_h[2] = '{1'b0, 1'b0};
    logic        m_deb = 1'b0;
    int          m_diff = 0;
    logic        press_dl[2] = '{1'b0, 1'b0};

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV(DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_step(btn_step),
        .sw_run(sw_run),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc(pc),
        .cpu_clk(cpu_clk),
        .halted(halted),
        .bp_hit(bp_hit),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int limit, input string name);
        int p0;
        p0 = pulses;
        for (int i = 0; i < limit && pulses == p0; i++) cyc_wait(1);
        checks++;
        if (pulses == p0) begin
            failures++;
            $display("FAIL %s actual=no_pulse required=pulse within %0d cycles", name, limit);
        end
    endtask

    // Model: spec rules evaluated per board clock edge
    always @(posedge clk or posedge reset) begin
        logic p, r, b, tick, rose;
        if (reset) begin
            mode = M_HALT; run_cycles = 0;
            m_cpu = 1'b0; m_halted = 1'b1; m_bp = 1'b0; m_count = 32'h0;
            btn_h = '{1'b0, 1'b0}; run_h = '{1'b0, 1'b0}; bpen_h = '{1'b0, 1'b0};
            m_deb = 1'b0; m_diff = 0; press_dl = '{1'b0, 1'b0};
        end else begin
            p = press_dl[1];
            r = run_h[1];
            b = bpen_h[1];
            tick = 1'b0;
            case (mode)
                M_HALT:  if (p) mode = M_STEP;
                         else if (r) begin mode = M_RUN; run_cycles = 0; end
                M_STEP:  begin tick = 1'b1; mode = M_HALT; end
                M_RUN:   if (!r) mode = M_HALT;
                         else begin
                             run_cycles++;
                             if (run_cycles % DIV == 0) begin
                                 if (b && pc == bp_addr) mode = M_BREAK;
                                 else tick = 1'b1;
                             end
                         end
                default: if (p) mode = M_STEP;
                         else if (!r) mode = M_HALT;
            endcase
            m_cpu = tick;
            if (tick) m_count = m_count + 32'd1;
            m_halted = (mode == M_HALT) || (mode == M_BREAK);
            m_bp = (mode == M_BREAK);

            rose = 1'b0;
            if (btn_h[1] != m_deb) begin
                m_diff++;
                if (m_diff == DEB) begin
                    m_deb = btn_h[1];
                    m_diff = 0;
                    rose = m_deb;
                end
            end else begin
                m_diff = 0;
            end
            press_dl[1] = press_dl[0];
            press_dl[0] = rose;
            btn_h[1] = btn_h[0];   btn_h[0] = btn_step;
            run_h[1] = run_h[0];   run_h[0] = sw_run;
            bpen_h[1] = bpen_h[0]; bpen_h[0] = bp_en;
        end
    end

    // Core stand-in: PC advances by 4 per executed cycle; pulse bookkeeping
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cpu_clk && !reset) begin
                pulses++;
                pulse_cyc.push_back(cyc);
                pc = pc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                check("cyc_cpu_clk", {31'b0, cpu_clk}, {31'b0, m_cpu});
                check("cyc_halted", {31'b0, halted}, {31'b0, m_halted});
                check("cyc_bp_hit", {31'b0, bp_hit}, {31'b0, m_bp});
                check("cyc_step_count", step_count, m_count);
            end
        end
    end

    initial begin
        int p0;
        int c1;
        logic [31:0] sc0;
        bit got;

        // Reset state
        reset = 1'b1;
        cyc_wait(3);
        check("rst_cpu_clk", {31'b0, cpu_clk}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd1);
        check("rst_bp_hit", {31'b0, bp_hit}, 32'd0);
        check("rst_step_count", step_count, 32'd0);
        reset = 1'b0;
        cyc_wait(2);

        // Debounce: a 3-cycle glitch is rejected, a 10-cycle press gives one step
        p0 = pulses;
        btn_step = 1'b1; cyc_wait(3);
        btn_step = 1'b0; cyc_wait(3);
        btn_step = 1'b1; cyc_wait(10);
        btn_step = 1'b0; cyc_wait(20);
        check("deb_pulses", pulses - p0, 32'd1);
        check("deb_step_count", step_count, 32'd1);
        check("deb_halted", {31'b0, halted}, 32'd1);

        // Free-run for 30 cycles: ticks on edges 6,9,..,30 after the switch change
        p0 = pulses;
        sc0 = step_count;
        pulse_cyc.delete();
        sw_run = 1'b1; cyc_wait(30);
        sw_run = 1'b0; cyc_wait(5);
        check("run_pulses", pulses - p0, 32'd9);
        check("run_step_delta", step_count - sc0, 32'd9);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("run_spacing", pulse_cyc[i] - pulse_cyc[i-1], 32'd3);
        p0 = pulses;
        cyc_wait(15);
        check("run_stopped", pulses - p0, 32'd0);

        // Reset in the middle of a pulse
        sw_run = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc_wait(1);
            if (cpu_clk) got = 1'b1;
        end
        check("midrun_pulse_seen", {31'b0, got}, 32'd1);
        reset = 1'b1;
        sw_run = 1'b0;
        #1;
        check("midrst_cpu_clk", {31'b0, cpu_clk}, 32'd0);
        check("midrst_halted", {31'b0, halted}, 32'd1);
        check("midrst_bp_hit", {31'b0, bp_hit}, 32'd0);
        check("midrst_step_count", step_count, 32'd0);
        cyc_wait(3);
        reset = 1'b0;
        p0 = pulses;
        cyc_wait(20);
        check("midrst_no_pulses", pulses - p0, 32'd0);

        // Breakpoint at 0xC: executes 0x0, 0x4, 0x8 then stops
        pc = 32'h0;
        bp_addr = 32'h0000000C;
        bp_en = 1'b1;
        p0 = pulses;
        sw_run = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            cyc_wait(1);
            if (bp_hit) got = 1'b1;
        end
        check("bp_reached", {31'b0, got}, 32'd1);
        check("bp_pulses", pulses - p0, 32'd3);
        check("bp_pc", pc, 32'h0000000C);
        check("bp_step_count", step_count, 32'd3);
        check("bp_halted", {31'b0, halted}, 32'd1);
        cyc_wait(6);
        check("bp_holds", {31'b0, bp_hit}, 32'd1);
        check("bp_no_more", pulses - p0, 32'd3);

        // Step over the breakpoint with the run switch still on
        btn_step = 1'b1;
        wait_pulse(30, "stepover_pulse");
        c1 = cyc;
        check("stepover_pc", pc, 32'h00000010);
        check("stepover_bp_hit", {31'b0, bp_hit}, 32'd0);
        check("stepover_count", step_count, 32'd4);
        wait_pulse(20, "resume_pulse");
        check("resume_gap", cyc - c1, 32'd4);
        check("resume_pc", pc, 32'h00000014);
        check("resume_count", step_count, 32'd5);
        sw_run = 1'b0;
        bp_en = 1'b0;
        btn_step = 1'b0;
        cyc_wait(20);

        // Counter wrap
        force dut.step_count = 32'hFFFFFFFF;
        m_count = 32'hFFFFFFFF;
        cyc_wait(1);
        release dut.step_count;
        cyc_wait(1);
        btn_step = 1'b1;
        wait_pulse(30, "wrap_pulse");
        check("wrap_count", step_count, 32'h00000000);
        btn_step = 1'b0;
        cyc_wait(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
